rf_access_scheduler: RTL and testbench

- Shares one reflection access port among NUM_REQ requesters, e.g. bench agents or debug masters.
- The access port is a single get/set channel onto reflected variables, addressed by handle index.
- Requests are granted round-robin and run one at a time, with a response timeout.
- Each response is routed back to the requester that issued it.

---
 rtl/rf_access_pkg.sv | 30 +++
 rtl/rf_rr_arbiter.sv | 37 +++
 rtl/rf_access_scheduler.sv | 143 ++++++++++++++
 tb/tb_rf_access_scheduler.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_access_pkg.sv
// Shared types for the reflection access scheduler: FSM states, access
// opcodes and the captured request record.
package rf_access_pkg;

  localparam int RF_ADDR_W = 16;
  localparam int RF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OP_GET = 1'b0,
    OP_SET = 1'b1
  } op_e;

  typedef struct packed {
    op_e                  op;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] wdata;
  } rf_access_req_t;

  function automatic op_e to_op(input logic write);
    return write ? OP_SET : OP_GET;
  endfunction

endpackage

// File: rtl/rf_rr_arbiter.sv
// Combinational round-robin picker: the first requester after ptr, with
// wrap-around, wins. Nothing is granted while en is low.
module rf_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  // Walk ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; ptr itself is checked last.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    sum     = '0;
    cand    = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rf_access_scheduler.sv
// Shares one reflection get/set access port among NUM_REQ requesters.
// One transaction in flight at a time, round-robin grant, response timeout,
// response routed back to the issuing requester.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | arbitrating; req_ready raised for the round-robin winner
//   ISSUE | acc_valid held with stable acc_* until acc_ready
//   WAIT  | counting cycles until acc_rsp_valid or timeout
//   RESP  | one-cycle rsp_valid strobe to the owner, then back to IDLE
module rf_access_scheduler
  import rf_access_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_error,
  output logic                      acc_valid,
  input  logic                      acc_ready,
  output logic                      acc_write,
  output logic [ADDR_W-1:0]         acc_addr,
  output logic [DATA_W-1:0]         acc_wdata,
  input  logic                      acc_rsp_valid,
  input  logic [DATA_W-1:0]         acc_rdata,
  input  logic                      acc_error
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  if (ADDR_W != RF_ADDR_W || DATA_W != RF_DATA_W) begin : g_width_check
    $error("rf_access_scheduler: ADDR_W/DATA_W must match rf_access_pkg widths");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_num_req_check
    $error("rf_access_scheduler: NUM_REQ must be 2..16");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_check
    $error("rf_access_scheduler: TIMEOUT must be 1..65535");
  end

  state_e           state;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] cnt;
  rf_access_req_t   req_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               arb_en;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // Grants only open in IDLE; held off during reset so req_ready reads 0.
  assign arb_en = (state == IDLE) && !rst;

  rf_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (last_grant),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign acc_write = (req_q.op == OP_SET);
  assign acc_addr  = req_q.addr;
  assign acc_wdata = req_q.wdata;

  // Scheduler FSM with pointer, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      owner      <= '0;
      cnt        <= '0;
      req_q      <= '0;
      acc_valid  <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_error  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            req_q      <= '{op:    to_op(req_write[gnt_idx]),
                            addr:  addr_arr[gnt_idx],
                            wdata: wdata_arr[gnt_idx]};
            owner      <= gnt_idx;
            last_grant <= gnt_idx;
            acc_valid  <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (acc_ready) begin
            acc_valid <= 1'b0;
            cnt       <= '0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A response landing on the timeout cycle takes priority.
          if (acc_rsp_valid) begin
            rsp_rdata <= (req_q.op == OP_SET) ? '0 : acc_rdata;
            rsp_error <= acc_error;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            rsp_rdata <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= NUM_REQ'(1) << owner;
            state     <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_access_scheduler.sv
// Directed bench for rf_access_scheduler with a response scoreboard.
module tb_rf_access_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic                      clk;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_error;
  logic                      acc_valid;
  logic                      acc_ready;
  logic                      acc_write;
  logic [ADDR_W-1:0]         acc_addr;
  logic [DATA_W-1:0]         acc_wdata;
  logic                      acc_rsp_valid;
  logic [DATA_W-1:0]         acc_rdata;
  logic                      acc_error;

  // Access-port model: auto mode answers every access one cycle after
  // acceptance with rdata {C0DE, addr}; manual mode follows m_* from the test.
  logic              auto_mode = 1'b0;
  logic              a_rsp     = 1'b0;
  logic [DATA_W-1:0] a_rdata   = '0;
  logic              m_ready   = 1'b0;
  logic              m_rsp     = 1'b0;
  logic [DATA_W-1:0] m_rdata   = '0;
  logic              m_err     = 1'b0;

  assign acc_ready     = auto_mode | m_ready;
  assign acc_rsp_valid = auto_mode ? a_rsp : m_rsp;
  assign acc_rdata     = auto_mode ? a_rdata : m_rdata;
  assign acc_error     = auto_mode ? 1'b0 : m_err;

  typedef struct {
    int                owner;
    logic [DATA_W-1:0] rdata;
    logic              err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  rf_access_scheduler #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_write(acc_write),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_rsp_valid(acc_rsp_valid), .acc_rdata(acc_rdata), .acc_error(acc_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    a_rsp   <= auto_mode && acc_valid && acc_ready;
    a_rdata <= {16'hC0DE, acc_addr};
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: every rsp_valid must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("req_ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      if (rsp_valid !== '0) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          check("rsp_owner", 64'(rsp_valid), 64'(4'd1 << e.owner));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_error", 64'(rsp_error), 64'(e.err));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int g, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[g]                 = 1'b1;
    req_write[g]                 = w;
    req_addr[g*ADDR_W +: ADDR_W] = a;
    req_wdata[g*DATA_W +: DATA_W] = d;
  endtask

  // Minimum-latency transaction for requester g, which is already requesting.
  task automatic serve(input int g, input logic [DATA_W-1:0] rd, input logic er);
    exp_t e;
    #1;
    check("serve_grant", 64'(req_ready), 64'(4'd1 << g));
    e.owner = g;
    e.rdata = req_write[g] ? '0 : rd;
    e.err   = er;
    sb.push_back(e);
    m_ready = 1'b1;
    tick();
    req_valid[g] = 1'b0;
    check("serve_acc_valid", 64'(acc_valid), 64'd1);
    tick();
    m_ready = 1'b0;
    m_rsp   = 1'b1;
    m_rdata = rd;
    m_err   = er;
    tick();
    m_rsp = 1'b0;
    m_err = 1'b0;
    check("serve_rsp_valid", 64'(rsp_valid), 64'(4'd1 << g));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   gl[$];
    int   gc[$];
    int   ngr;
    int   e_cyc;
    int   t_cyc;
    logic got;
    exp_t e;

    rst       = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_acc_valid", 64'(acc_valid), 64'd0);
    check("rst_acc_addr", 64'(acc_addr), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);

    // Single get at minimum latency
    set_req(0, 1'b0, 16'h0012, '0);
    #1;
    check("get_ready", 64'(req_ready), 64'h1);
    e.owner = 0; e.rdata = 32'hDEADBEEF; e.err = 1'b0;
    sb.push_back(e);
    m_ready = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    check("get_acc_valid", 64'(acc_valid), 64'd1);
    check("get_acc_addr", 64'(acc_addr), 64'h0012);
    check("get_acc_write", 64'(acc_write), 64'd0);
    tick();
    check("get_acc_valid_drop", 64'(acc_valid), 64'd0);
    m_ready = 1'b0;
    m_rsp   = 1'b1;
    m_rdata = 32'hDEADBEEF;
    tick();
    m_rsp = 1'b0;
    check("get_rsp_cycle3", 64'(rsp_valid), 64'h1);
    tick();
    check("get_rsp_valid_low", 64'(rsp_valid), 64'd0);
    check("get_rdata_hold", 64'(rsp_rdata), 64'hDEADBEEF);

    // Round-robin with all four requesting, fresh pointer
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 16'h0020 + 16'(i), '0);
    for (int k = 0; k < 6; k++) begin
      e.owner = k % NUM_REQ;
      e.rdata = {16'hC0DE, 16'h0020 + 16'(k % NUM_REQ)};
      e.err   = 1'b0;
      sb.push_back(e);
    end
    auto_mode = 1'b1;
    ngr = 0;
    for (int k = 0; k < 60 && ngr < 6; k++) begin
      #1;
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) gl.push_back(i);
        gc.push_back(cyc);
        ngr++;
      end
      tick();
    end
    req_valid = '0;
    check("rr_grant_count", 64'(ngr), 64'd6);
    for (int k = 0; k < gl.size(); k++) begin
      check("rr_order", 64'(gl[k]), 64'(k % NUM_REQ));
      if (k > 0) check("rr_spacing", 64'(gc[k] - gc[k-1]), 64'd4);
    end
    for (int k = 0; k < 30 && sb.size() > 0; k++) tick();
    check("rr_drained", 64'(sb.size()), 64'd0);
    tick();
    auto_mode = 1'b0;
    tick();

    // Set with 5 cycles of back-pressure; set returns rdata 0
    set_req(2, 1'b1, 16'h0100, 32'h5A5A5A5A);
    #1;
    check("set_ready", 64'(req_ready), 64'h4);
    e.owner = 2; e.rdata = '0; e.err = 1'b0;
    sb.push_back(e);
    tick();
    req_valid[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("bp_acc_valid", 64'(acc_valid), 64'd1);
      check("bp_acc_write", 64'(acc_write), 64'd1);
      check("bp_acc_addr", 64'(acc_addr), 64'h0100);
      check("bp_acc_wdata", 64'(acc_wdata), 64'h5A5A5A5A);
      tick();
    end
    m_ready = 1'b1;
    check("bp_acc_valid_last", 64'(acc_valid), 64'd1);
    tick();
    m_ready = 1'b0;
    check("bp_acc_valid_drop", 64'(acc_valid), 64'd0);
    m_rsp   = 1'b1;
    m_rdata = 32'hFFFFFFFF;
    tick();
    m_rsp = 1'b0;
    check("set_rsp_valid", 64'(rsp_valid), 64'h4);
    tick();

    // Timeout: no response ever comes
    set_req(0, 1'b0, 16'h0033, '0);
    #1;
    check("to_ready", 64'(req_ready), 64'h1);
    e.owner = 0; e.rdata = '0; e.err = 1'b1;
    sb.push_back(e);
    m_ready = 1'b1;
    tick();
    req_valid[0] = 1'b0;
    tick();
    e_cyc   = cyc;
    m_ready = 1'b0;
    got     = 1'b0;
    t_cyc   = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      if (rsp_valid !== '0) begin
        got   = 1'b1;
        t_cyc = cyc;
      end
    end
    check("to_seen", 64'(got), 64'd1);
    check("to_latency", 64'(t_cyc - e_cyc), 64'd8);
    tick();
    set_req(1, 1'b0, 16'h0044, '0);
    serve(1, 32'h12345678, 1'b0);

    // Response on the final WAIT cycle beats the timeout
    set_req(3, 1'b0, 16'h0055, '0);
    #1;
    check("edge_ready", 64'(req_ready), 64'h8);
    e.owner = 3; e.rdata = 32'h1; e.err = 1'b0;
    sb.push_back(e);
    m_ready = 1'b1;
    tick();
    req_valid[3] = 1'b0;
    tick();
    e_cyc   = cyc;
    m_ready = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    m_rsp   = 1'b1;
    m_rdata = 32'h1;
    m_err   = 1'b0;
    tick();
    m_rsp = 1'b0;
    check("edge_latency", 64'(cyc - e_cyc), 64'd8);
    check("edge_rsp_valid", 64'(rsp_valid), 64'h8);
    tick();

    // Reset during WAIT drops the transaction and restores the pointer
    set_req(2, 1'b1, 16'h0200, 32'h11112222);
    #1;
    check("rw_ready", 64'(req_ready), 64'h4);
    m_ready = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    tick();
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_acc_valid", 64'(acc_valid), 64'd0);
    check("rw_acc_write", 64'(acc_write), 64'd0);
    check("rw_acc_addr", 64'(acc_addr), 64'd0);
    check("rw_acc_wdata", 64'(acc_wdata), 64'd0);
    check("rw_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rw_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rw_rsp_error", 64'(rsp_error), 64'd0);
    m_rsp   = 1'b1;
    m_rdata = 32'h00000BAD;
    tick();
    m_rsp = 1'b0;
    check("late_rsp_ignored", 64'(rsp_valid), 64'd0);
    check("late_acc_valid", 64'(acc_valid), 64'd0);
    tick();
    check("late_rsp_ignored2", 64'(rsp_valid), 64'd0);
    set_req(1, 1'b0, 16'h0011, '0);
    set_req(3, 1'b0, 16'h0033, '0);
    serve(1, 32'hA1A1A1A1, 1'b0);
    serve(3, 32'hB3B3B3B3, 1'b1);

    tick();
    tick();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
